hot_event_dispatcher: RTL
=========================

Name: hot_event_dispatcher

Overview:
- Upstream feeder and downstream consumer around priority_encoder_13bit.
- Captures single-cycle event pulses from 13 sources into a pending register and feeds the masked pending vector to the encoder.
- Issues the winning index, lowest index first, through a registered valid/ready output stage.
- Clears each served bit as it is dispatched; sits between the event sources and the per-index service logic.

Parameters:
- N_EVT, 13, number of event sources; fixed to match the encoder width, other values unsupported.
- IDX_W, 4, index width; fixed to 4.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- evt_i  input  13  event pulses; bit k high for one cycle = one event on source k.
- evt_mask_i  input  13  1 = source eligible for dispatch; masked bits stay pending.
- flush_i  input  1  synchronous clear of pending and output stage.
- ready_i  input  1  consumer accepts idx_o this cycle.
- idx_o  output  4  dispatched source index, registered.
- valid_o  output  1  idx_o valid, registered.
- pending_o  output  13  current pending register.
- overflow_o  output  1  sticky: an event was merged into an already-pending bit.
- overflow_clr_i  input  1  clears overflow_o.

Behaviour:
- Reset (rst_ni low, async): pending = 0, idx_o = 0, valid_o = 0, overflow_o = 0.
- Encoder input: sel_vec = pending & evt_mask_i. It is purely combinational and yields enc_idx and enc_valid.
- Output stage load condition: load = enc_valid & (~valid_o | ready_i).
- On load, next cycle: idx_o = enc_idx, valid_o = 1, and pending[enc_idx] is cleared.
- If valid_o & ready_i & ~enc_valid, then valid_o goes to 0 next cycle; idx_o holds its last value.
- While valid_o & ~ready_i, idx_o and valid_o are held stable; pending keeps accumulating.
- Pending update per bit: next = (pending & ~clr_mask) | evt_i.
  - Set wins over clear: an event arriving on the bit being loaded leaves that bit pending.
  - That event is a new event; it is not an overflow.
- Overflow: set when evt_i[k] & pending[k] & ~clr_mask[k] for any k.
  - overflow_clr_i takes priority over a same-cycle set; overflow_o reads 0 next cycle.
- Latency: event at edge t, pending at t+1, valid_o at t+2 when the output stage is free. One dispatch per cycle with ready_i tied high.
- Back-to-back: with ready_i high the next winner loads in the same cycle the current index is accepted, giving no bubble.
- Index ordering: fixed priority, lowest index first. A low index arriving while a higher index waits in the output stage is dispatched after it (no preemption).
- Mask change: masking a bit held in the output stage does not retract it.
- flush_i: next cycle pending = 0 and valid_o = 0. evt_i in the same cycle is dropped, and overflow_o is unaffected.
- Async reset mid-handshake discards everything; no residual valid.

Decomposition:
- Shared package: N_EVT = 13, IDX_W = 4.
- Sub-module: instantiate priority_encoder_13bit unchanged for sel_vec to enc_idx/enc_valid.
- The rest (pending register, output stage, overflow flag) stays in one module, about 150 lines.

Test Plan:
- Reset, all-zero inputs: all outputs 0; evt_i = 13'h0001 one cycle, ready_i = 1 → valid_o = 1, idx_o = 0 two cycles later, then valid_o = 0.
- evt_i = 13'h1005 (bits 0, 2, 12) in one cycle, ready_i = 1 → idx_o sequence 0, 2, 12 on consecutive cycles; pending_o reaches 0.
- Backpressure: bits 3 and 5 pending, ready_i = 0 for 4 cycles → idx_o = 3 held with valid_o = 1. Raise ready_i → 3, then 5.
- Mask: evt_i = 13'h0003, evt_mask_i = 13'h1FFE → only idx 1 issued; bit 0 stays in pending_o. Unmask → idx 0 issued.
- Overflow: evt_i bit 7 twice with ready_i = 0 and bit 7 masked → overflow_o = 1; overflow_clr_i pulse → 0. Event on bit being loaded → bit re-pending, overflow_o = 0.
- flush_i with pending = 13'h00F0 and valid_o = 1 → next cycle pending_o = 0 and valid_o = 0. Async reset asserted mid-stream → outputs 0 immediately.

Source files
------------

// File: rtl/hot_event_dispatcher_pkg.sv
// Shared widths and helpers for the hot event dispatcher and its encoder.
package hot_event_dispatcher_pkg;

    localparam int unsigned N_EVT = 13;
    localparam int unsigned IDX_W = 4;

    function automatic logic [N_EVT-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_EVT-1:0] vec;
        vec = '0;
        for (int unsigned i = 0; i < N_EVT; i++) begin
            if (idx == IDX_W'(i)) vec[i] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/priority_encoder_13bit.sv
// Fixed-priority encoder: reports the lowest set bit of a 13-bit vector.
module priority_encoder_13bit
    import hot_event_dispatcher_pkg::*;
(
    input  logic [N_EVT-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = |vec_i;
        // Scan downwards so the lowest set bit is the final assignment.
        for (int i = N_EVT - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/hot_event_dispatcher.sv
// Captures event pulses into a pending register and dispatches the lowest
// eligible index through a registered valid/ready output stage.
module hot_event_dispatcher
    import hot_event_dispatcher_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_EVT-1:0] evt_i,
    input  logic [N_EVT-1:0] evt_mask_i,
    input  logic             flush_i,
    input  logic             ready_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o,
    output logic [N_EVT-1:0] pending_o,
    output logic             overflow_o,
    input  logic             overflow_clr_i
);

    logic [N_EVT-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;

    logic [N_EVT-1:0] sel_vec;
    logic [N_EVT-1:0] clr_mask;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;
    logic             load;

    assign sel_vec = pending_q & evt_mask_i;

    priority_encoder_13bit u_enc (
        .vec_i   (sel_vec),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    assign load     = enc_valid & (~valid_q | ready_i);
    assign clr_mask = load ? idx_to_onehot(enc_idx) : '0;

    always_comb begin
        pending_d  = pending_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;

        if (flush_i) begin
            pending_d = '0;
            valid_d   = 1'b0;
        end else begin
            // A fresh event on the bit being dispatched re-arms it; not an overflow.
            pending_d = (pending_q & ~clr_mask) | evt_i;
            if (|(evt_i & pending_q & ~clr_mask)) overflow_d = 1'b1;
            if (load) begin
                idx_d   = enc_idx;
                valid_d = 1'b1;
            end else if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end
        end

        if (overflow_clr_i) overflow_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q  <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending_o  = pending_q;
    assign idx_o      = idx_q;
    assign valid_o    = valid_q;
    assign overflow_o = overflow_q;

endmodule
